// File: rtl/mbus_arb2_pkg.sv
// mbus_arb2_pkg
//   Shared types for the two-master bus arbiter: the bus request record,
//   the arbiter FSM state encoding and the master index type.
//   No ports (package).
package mbus_arb2_pkg;

  // Widest address the request record can carry; narrower buses use the
  // low ADDR_W bits and leave the rest zero.
  localparam int ADDR_W_MAX = 64;

  typedef logic mst_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_MAX-1:0] addr;
    logic [3:0]            be;
    logic [31:0]           wdata;
  } bus_req_t;

  function automatic mst_idx_t other_mst(input mst_idx_t idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/mbus_arb2_if.sv
// mbus_arb2_if
//   Bundles every master-side, slave-side and status signal of the arbiter.
//   Signal suffixes are written from the arbiter's point of view.
//   modport slave  : used by the arbiter itself (it serves both masters)
//   modport master : used by whatever drives the masters and models the slave
//   Parameters: ADDR_W (address width), RD_DEPTH (outstanding read depth)
interface mbus_arb2_if #(
  parameter int ADDR_W   = 32,
  parameter int RD_DEPTH = 4
);
  localparam int CNT_W = $clog2(RD_DEPTH) + 1;

  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_bi;
  logic [3:0]        m0_be_bi;
  logic [31:0]       m0_wdata_bi;
  logic              m0_ack_o;
  logic              m0_resp_o;
  logic [31:0]       m0_rdata_bo;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_bi;
  logic [3:0]        m1_be_bi;
  logic [31:0]       m1_wdata_bi;
  logic              m1_ack_o;
  logic              m1_resp_o;
  logic [31:0]       m1_rdata_bo;

  logic              s_req_o;
  logic              s_we_o;
  logic [ADDR_W-1:0] s_addr_bo;
  logic [3:0]        s_be_bo;
  logic [31:0]       s_wdata_bo;
  logic              s_ack_i;
  logic              s_resp_i;
  logic [31:0]       s_rdata_bi;

  logic [CNT_W-1:0]  rd_cnt_o;
  logic              rsp_err_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_bi, m0_be_bi, m0_wdata_bi,
    output m0_ack_o, m0_resp_o, m0_rdata_bo,
    input  m1_req_i, m1_we_i, m1_addr_bi, m1_be_bi, m1_wdata_bi,
    output m1_ack_o, m1_resp_o, m1_rdata_bo,
    output s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo,
    input  s_ack_i, s_resp_i, s_rdata_bi,
    output rd_cnt_o, rsp_err_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_bi, m0_be_bi, m0_wdata_bi,
    input  m0_ack_o, m0_resp_o, m0_rdata_bo,
    output m1_req_i, m1_we_i, m1_addr_bi, m1_be_bi, m1_wdata_bi,
    input  m1_ack_o, m1_resp_o, m1_rdata_bo,
    input  s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo,
    output s_ack_i, s_resp_i, s_rdata_bi,
    input  rd_cnt_o, rsp_err_o
  );

endinterface

// File: rtl/mbus_arb2_tag_fifo.sv
// mbus_tag_fifo
//   In-order tag FIFO remembering which master owns each outstanding read.
//   Ports: clk_i, arst_i (async, active-high), push_i/din_i, pop_i/dout_o,
//          full_o, empty_o, count_o (registered occupancy).
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module mbus_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mbus_arb2.sv
// mbus_arb2
//   Two-master round-robin arbiter onto a single slave bus, with in-order
//   read-response routing through a tag FIFO.
//   Ports: clk_i, arst_i (async, active-high), bus (mbus_arb2_if.slave:
//          master 0/1 request/ack/response, slave request/ack/response,
//          rd_cnt_o outstanding reads, rsp_err_o sticky orphan response).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | pick a master this cycle (round robin on ties)
//   ST_HOLD | slave stalled; keep driving the previously picked master
module mbus_arb2
  import mbus_arb2_pkg::*;
#(
  parameter int RD_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input logic        clk_i,
  input logic        arst_i,
  mbus_arb2_if.slave bus
);
  localparam int CNT_W = $clog2(RD_DEPTH) + 1;

  arb_state_t       state_q, state_d;
  mst_idx_t         held_q, rr_last_q, gnt_idx;
  logic             gnt_vld, accept;
  logic             elig0, elig1;
  logic             rsp_err_q;
  bus_req_t         req_m0, req_m1, req_sel;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  mst_idx_t         fifo_head;
  logic [CNT_W-1:0] rd_cnt;

  always_comb begin
    req_m0                   = '0;
    req_m0.we                = bus.m0_we_i;
    req_m0.addr[ADDR_W-1:0]  = bus.m0_addr_bi;
    req_m0.be                = bus.m0_be_bi;
    req_m0.wdata             = bus.m0_wdata_bi;
    req_m1                   = '0;
    req_m1.we                = bus.m1_we_i;
    req_m1.addr[ADDR_W-1:0]  = bus.m1_addr_bi;
    req_m1.be                = bus.m1_be_bi;
    req_m1.wdata             = bus.m1_wdata_bi;
  end

  // Full check uses the registered count, so a pop in the same cycle does
  // not let a new read through until the next cycle.
  assign elig0 = bus.m0_req_i & (bus.m0_we_i | ~fifo_full);
  assign elig1 = bus.m1_req_i & (bus.m1_we_i | ~fifo_full);

  always_comb begin
    state_d = state_q;
    gnt_vld = 1'b0;
    gnt_idx = held_q;
    case (state_q)
      ST_IDLE: begin
        if (elig0 && elig1) begin
          gnt_vld = 1'b1;
          gnt_idx = other_mst(rr_last_q);
        end else if (elig0) begin
          gnt_vld = 1'b1;
          gnt_idx = 1'b0;
        end else if (elig1) begin
          gnt_vld = 1'b1;
          gnt_idx = 1'b1;
        end
        if (gnt_vld && !bus.s_ack_i) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // A held master dropping req is a protocol violation: abandon it.
        gnt_vld = held_q ? bus.m1_req_i : bus.m0_req_i;
        if (!gnt_vld || bus.s_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Keep the slave side quiet while reset is asserted.
    if (arst_i) gnt_vld = 1'b0;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      held_q    <= 1'b0;
      rr_last_q <= 1'b1;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) held_q <= gnt_idx;
      if (accept) rr_last_q <= gnt_idx;
      if (bus.s_resp_i && fifo_empty) rsp_err_q <= 1'b1;
    end
  end

  assign req_sel = gnt_idx ? req_m1 : req_m0;
  assign accept  = gnt_vld & bus.s_ack_i;

  if (ADDR_W < ADDR_W_MAX) begin : g_addr_pad
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_sel.addr[ADDR_W_MAX-1:ADDR_W];
  end

  assign bus.s_req_o    = gnt_vld;
  assign bus.s_we_o     = gnt_vld & req_sel.we;
  assign bus.s_addr_bo  = gnt_vld ? req_sel.addr[ADDR_W-1:0] : '0;
  assign bus.s_be_bo    = gnt_vld ? req_sel.be : '0;
  assign bus.s_wdata_bo = gnt_vld ? req_sel.wdata : '0;

  assign bus.m0_ack_o = accept & (gnt_idx == 1'b0);
  assign bus.m1_ack_o = accept & (gnt_idx == 1'b1);

  assign fifo_push = accept & ~req_sel.we;
  assign fifo_pop  = bus.s_resp_i & ~fifo_empty;

  mbus_tag_fifo #(
    .DEPTH (RD_DEPTH),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (fifo_push),
    .din_i   (gnt_idx),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rd_cnt)
  );

  assign bus.m0_resp_o   = fifo_pop & (fifo_head == 1'b0);
  assign bus.m1_resp_o   = fifo_pop & (fifo_head == 1'b1);
  assign bus.m0_rdata_bo = bus.m0_resp_o ? bus.s_rdata_bi : '0;
  assign bus.m1_rdata_bo = bus.m1_resp_o ? bus.s_rdata_bi : '0;

  assign bus.rd_cnt_o  = rd_cnt;
  assign bus.rsp_err_o = rsp_err_q;

endmodule

// File: tb/tb_mbus_arb2.sv
module tb_mbus_arb2;
  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;

  always #5 clk_i = ~clk_i;

  mbus_arb2_if #(.ADDR_W(32), .RD_DEPTH(4)) bus ();

  mbus_arb2 #(.RD_DEPTH(4), .ADDR_W(32)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr;
    logic        ack, resp;
    logic [31:0] rdata;
    logic        e_sreq, e_swe;
    logic [31:0] e_saddr;
    logic        e_a0, e_a1, e_r0, e_r1;
    logic [31:0] e_d0, e_d1;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 17;
  localparam logic [31:0] D = 32'hDEAD_0000;
  vec_t vt [NV];

  function automatic vec_t mk(
    input logic m0r, m0w, input logic [31:0] m0a,
    input logic m1r, m1w, input logic [31:0] m1a,
    input logic ack, resp, input logic [31:0] rd,
    input logic sreq, swe, input logic [31:0] sa,
    input logic a0, a1, r0, r1, input logic [31:0] d0, d1,
    input logic [2:0] cnt);
    vec_t v;
    v.m0_req = m0r; v.m0_we = m0w; v.m0_addr = m0a;
    v.m1_req = m1r; v.m1_we = m1w; v.m1_addr = m1a;
    v.ack = ack; v.resp = resp; v.rdata = rd;
    v.e_sreq = sreq; v.e_swe = swe; v.e_saddr = sa;
    v.e_a0 = a0; v.e_a1 = a1; v.e_r0 = r0; v.e_r1 = r1;
    v.e_d0 = d0; v.e_d1 = d1; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_bi = '0;
    bus.m0_be_bi = 4'hF; bus.m0_wdata_bi = 32'h0000_00A0;
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_bi = '0;
    bus.m1_be_bi = 4'h3; bus.m1_wdata_bi = 32'h0000_00B1;
    bus.s_ack_i = 1'b0; bus.s_resp_i = 1'b0; bus.s_rdata_bi = D;
  endtask

  // Called at posedge+1; asserts reset, checks outputs, releases mid-cycle.
  task automatic pulse_reset(input string tag);
    arst_i = 1'b1;
    #1;
    chk({tag, " rst rd_cnt"}, 64'(bus.rd_cnt_o), 0);
    chk({tag, " rst rsp_err"}, 64'(bus.rsp_err_o), 0);
    chk({tag, " rst s_req"}, 64'(bus.s_req_o), 0);
    chk({tag, " rst m0_ack"}, 64'(bus.m0_ack_o), 0);
    chk({tag, " rst m0_resp"}, 64'(bus.m0_resp_o), 0);
    #1;
    arst_i = 1'b0;
    idle_inputs();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    //            m0 r,w,addr      m1 r,w,addr      ack,resp,rdata    sreq,swe,saddr   a0,a1,r0,r1  d0,d1                cnt
    vt[0]  = mk(1,0,32'h100, 1,0,32'h200, 1,0,D,          1,0,32'h100, 1,0,0,0, 32'h0,32'h0,       3'd0);
    vt[1]  = mk(0,0,32'h000, 1,0,32'h200, 1,0,D,          1,0,32'h200, 0,1,0,0, 32'h0,32'h0,       3'd1);
    vt[2]  = mk(0,0,32'h000, 0,0,32'h000, 0,1,32'hAAAA,   0,0,32'h000, 0,0,1,0, 32'hAAAA,32'h0,    3'd2);
    vt[3]  = mk(0,0,32'h000, 0,0,32'h000, 0,1,32'hBBBB,   0,0,32'h000, 0,0,0,1, 32'h0,32'hBBBB,    3'd1);
    vt[4]  = mk(1,1,32'h030, 0,0,32'h000, 1,0,D,          1,1,32'h030, 1,0,0,0, 32'h0,32'h0,       3'd0);
    vt[5]  = mk(1,1,32'h010, 0,0,32'h000, 0,0,D,          1,1,32'h010, 0,0,0,0, 32'h0,32'h0,       3'd0);
    vt[6]  = mk(1,1,32'h010, 1,0,32'h020, 0,0,D,          1,1,32'h010, 0,0,0,0, 32'h0,32'h0,       3'd0);
    vt[7]  = mk(1,1,32'h010, 1,0,32'h020, 0,0,D,          1,1,32'h010, 0,0,0,0, 32'h0,32'h0,       3'd0);
    vt[8]  = mk(1,1,32'h010, 1,0,32'h020, 1,0,D,          1,1,32'h010, 1,0,0,0, 32'h0,32'h0,       3'd0);
    vt[9]  = mk(0,0,32'h000, 1,0,32'h020, 1,0,D,          1,0,32'h020, 0,1,0,0, 32'h0,32'h0,       3'd0);
    vt[10] = mk(1,0,32'h040, 1,1,32'h050, 1,0,D,          1,0,32'h040, 1,0,0,0, 32'h0,32'h0,       3'd1);
    vt[11] = mk(1,0,32'h044, 1,1,32'h050, 1,0,D,          1,1,32'h050, 0,1,0,0, 32'h0,32'h0,       3'd2);
    vt[12] = mk(0,0,32'h000, 0,0,32'h000, 0,1,32'h1111,   0,0,32'h000, 0,0,0,1, 32'h0,32'h1111,    3'd2);
    vt[13] = mk(0,0,32'h000, 0,0,32'h000, 0,1,32'h2222,   0,0,32'h000, 0,0,1,0, 32'h2222,32'h0,    3'd1);
    vt[14] = mk(0,0,32'h000, 1,1,32'h060, 0,0,D,          1,1,32'h060, 0,0,0,0, 32'h0,32'h0,       3'd0);
    vt[15] = mk(1,1,32'h070, 0,0,32'h000, 1,0,D,          0,0,32'h000, 0,0,0,0, 32'h0,32'h0,       3'd0);
    vt[16] = mk(1,1,32'h070, 0,0,32'h000, 1,0,D,          1,1,32'h070, 1,0,0,0, 32'h0,32'h0,       3'd0);

    idle_inputs();
    // Reset held with a live request: slave side must stay silent.
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b1; bus.s_ack_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("init s_req", 64'(bus.s_req_o), 0);
    chk("init m0_ack", 64'(bus.m0_ack_o), 0);
    chk("init rd_cnt", 64'(bus.rd_cnt_o), 0);
    chk("init rsp_err", 64'(bus.rsp_err_o), 0);
    arst_i = 1'b0;
    idle_inputs();
    step();

    for (int i = 0; i < NV; i++) begin
      bus.m0_req_i = vt[i].m0_req; bus.m0_we_i = vt[i].m0_we; bus.m0_addr_bi = vt[i].m0_addr;
      bus.m1_req_i = vt[i].m1_req; bus.m1_we_i = vt[i].m1_we; bus.m1_addr_bi = vt[i].m1_addr;
      bus.s_ack_i = vt[i].ack; bus.s_resp_i = vt[i].resp; bus.s_rdata_bi = vt[i].rdata;
      #1;
      chk($sformatf("v%0d s_req", i),    64'(bus.s_req_o),     64'(vt[i].e_sreq));
      chk($sformatf("v%0d s_we", i),     64'(bus.s_we_o),      64'(vt[i].e_swe));
      chk($sformatf("v%0d s_addr", i),   64'(bus.s_addr_bo),   64'(vt[i].e_saddr));
      chk($sformatf("v%0d m0_ack", i),   64'(bus.m0_ack_o),    64'(vt[i].e_a0));
      chk($sformatf("v%0d m1_ack", i),   64'(bus.m1_ack_o),    64'(vt[i].e_a1));
      chk($sformatf("v%0d m0_resp", i),  64'(bus.m0_resp_o),   64'(vt[i].e_r0));
      chk($sformatf("v%0d m1_resp", i),  64'(bus.m1_resp_o),   64'(vt[i].e_r1));
      chk($sformatf("v%0d m0_rdata", i), 64'(bus.m0_rdata_bo), 64'(vt[i].e_d0));
      chk($sformatf("v%0d m1_rdata", i), 64'(bus.m1_rdata_bo), 64'(vt[i].e_d1));
      chk($sformatf("v%0d rd_cnt", i),   64'(bus.rd_cnt_o),    64'(vt[i].e_cnt));
      step();
    end
    idle_inputs();
    #1;
    chk("tbl rsp_err", 64'(bus.rsp_err_o), 0);

    // Fill the tag FIFO from master 1, block a 5th read, let a write past.
    pulse_reset("fill");
    for (int i = 0; i < 4; i++) begin
      bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_bi = 32'h400 + 32'(i);
      bus.s_ack_i = 1'b1;
      #1;
      chk($sformatf("fill%0d m1_ack", i), 64'(bus.m1_ack_o), 1);
      step();
    end
    chk("full rd_cnt", 64'(bus.rd_cnt_o), 4);
    bus.m1_addr_bi = 32'h404;
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b1; bus.m0_addr_bi = 32'h300;
    #1;
    chk("full m1_ack", 64'(bus.m1_ack_o), 0);
    chk("full m0 wr ack", 64'(bus.m0_ack_o), 1);
    chk("full s_addr", 64'(bus.s_addr_bo), 64'h300);
    step();
    chk("full after wr cnt", 64'(bus.rd_cnt_o), 4);
    bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0;
    bus.s_resp_i = 1'b1; bus.s_rdata_bi = 32'h5A5A;
    #1;
    chk("pop+rd s_req", 64'(bus.s_req_o), 0);
    chk("pop+rd m1_ack", 64'(bus.m1_ack_o), 0);
    chk("pop+rd m1_resp", 64'(bus.m1_resp_o), 1);
    chk("pop+rd m1_rdata", 64'(bus.m1_rdata_bo), 64'h5A5A);
    step();
    bus.s_resp_i = 1'b0;
    #1;
    chk("freed rd_cnt", 64'(bus.rd_cnt_o), 3);
    chk("freed m1_ack", 64'(bus.m1_ack_o), 1);
    chk("freed s_addr", 64'(bus.s_addr_bo), 64'h404);
    step();
    chk("refull rd_cnt", 64'(bus.rd_cnt_o), 4);
    bus.m1_req_i = 1'b0; bus.s_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_resp_i = 1'b1; bus.s_rdata_bi = 32'hC0 + 32'(i);
      #1;
      chk($sformatf("drain%0d m1_resp", i), 64'(bus.m1_resp_o), 1);
      chk($sformatf("drain%0d m0_resp", i), 64'(bus.m0_resp_o), 0);
      chk($sformatf("drain%0d m1_rdata", i), 64'(bus.m1_rdata_bo), 64'(32'hC0 + 32'(i)));
      step();
    end
    bus.s_resp_i = 1'b0;
    chk("drained rd_cnt", 64'(bus.rd_cnt_o), 0);
    chk("drained rsp_err", 64'(bus.rsp_err_o), 0);

    // Orphan response with nothing outstanding.
    bus.s_resp_i = 1'b1; bus.s_rdata_bi = 32'h7777;
    #1;
    chk("orph m0_resp", 64'(bus.m0_resp_o), 0);
    chk("orph m1_resp", 64'(bus.m1_resp_o), 0);
    chk("orph m0_rdata", 64'(bus.m0_rdata_bo), 0);
    chk("orph err before edge", 64'(bus.rsp_err_o), 0);
    step();
    bus.s_resp_i = 1'b0;
    chk("orph err set", 64'(bus.rsp_err_o), 1);
    step();
    step();
    chk("orph err sticky", 64'(bus.rsp_err_o), 1);
    pulse_reset("orph");
    chk("orph err cleared", 64'(bus.rsp_err_o), 0);

    // Reset with two reads outstanding discards their tags.
    bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_bi = 32'h600; bus.s_ack_i = 1'b1;
    step();
    step();
    idle_inputs();
    chk("two rd rd_cnt", 64'(bus.rd_cnt_o), 2);
    arst_i = 1'b1;
    #1;
    chk("mid rst rd_cnt", 64'(bus.rd_cnt_o), 0);
    #1;
    arst_i = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.s_resp_i = 1'b1; bus.s_rdata_bi = 32'h900 + 32'(i);
      #1;
      chk($sformatf("stale%0d m0_resp", i), 64'(bus.m0_resp_o), 0);
      chk($sformatf("stale%0d m1_resp", i), 64'(bus.m1_resp_o), 0);
      step();
    end
    bus.s_resp_i = 1'b0;
    chk("stale rsp_err", 64'(bus.rsp_err_o), 1);
    chk("stale rd_cnt", 64'(bus.rd_cnt_o), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mbus_arb2.md
MBUS_ARB2 -- requirements
Module: mbus_arb2

Interface
REQ-001 Parameter RD_DEPTH, default 4, maximum outstanding reads tracked (power of 2, >=2).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 arst_i  in  1  reset, asynchronous, active-high.
REQ-005 mN_req_i / mN_we_i  in  1 each  master N (N=0,1) request valid / write-enable.
REQ-006 mN_addr_bi  in  ADDR_W; mN_be_bi  in  4; mN_wdata_bi  in  32  master N request fields.
REQ-007 mN_ack_o / mN_resp_o  out  1 each; mN_rdata_bo  out  32  master N accept / read-response / read data.
REQ-008 s_req_o / s_we_o  out  1; s_addr_bo  out  ADDR_W; s_be_bo  out  4; s_wdata_bo  out  32  slave request.
REQ-009 s_ack_i / s_resp_i  in  1; s_rdata_bi  in  32  slave accept / read response.
REQ-010 rd_cnt_o  out  $clog2(RD_DEPTH)+1  outstanding reads; rsp_err_o  out  1  sticky orphan-response flag.

Function
REQ-011 Transfer accepted in a cycle iff s_req_o & s_ack_i; granted master sees mN_ack_o = s_ack_i, other master ack 0.
REQ-012 Arbiter FSM states IDLE, HOLD; IDLE selects master, HOLD keeps last selected master until accepted.
REQ-013 IDLE: one eligible requester -> grant it; both eligible -> grant master opposite to rr_last; grant combinational same cycle.
REQ-014 IDLE -> HOLD when grant issued and s_ack_i=0; HOLD -> IDLE on acceptance; IDLE stays IDLE on same-cycle acceptance.
REQ-015 HOLD: s_req_o and all request fields driven from held master regardless of other master's req.
REQ-016 HOLD with held master dropping req (protocol violation): s_req_o=0, return to IDLE next cycle.
REQ-017 rr_last updated to granted master index on every accepted transfer only.
REQ-018 Master eligible if req=1 and (we=1 or rd_cnt_o<RD_DEPTH); read blocked while full, write passes.
REQ-019 No grant -> s_req_o=0, s_we_o=0, addr/be/wdata=0.
REQ-020 Accepted read pushes granted master index into in-order tag FIFO of RD_DEPTH entries.
REQ-021 s_resp_i=1 with FIFO non-empty: pop head, route resp/rdata to that master same cycle (combinational); other master resp=0, rdata=0.
REQ-022 Push and pop same cycle: both performed, rd_cnt_o unchanged; pointers wrap modulo RD_DEPTH.
REQ-023 Full blocking uses registered count only; same-cycle pop does not unblock a read.
REQ-024 s_resp_i=1 with FIFO empty: response dropped, both mN_resp_o=0, rsp_err_o set next cycle, held until reset.
REQ-025 Writes produce no response and no FIFO entry.

Reset
REQ-026 arst_i asserted: FSM=IDLE, rr_last=1 (master 0 wins first tie), FIFO pointers=0, rd_cnt_o=0, rsp_err_o=0, immediately, asynchronously.
REQ-027 Reset mid-transaction discards held grant and all outstanding tags; later slave responses are orphans per REQ-024.
REQ-028 All outputs 0 during reset (combinational outputs follow zero state and inputs gated by FSM=IDLE, no tags).

Structure
REQ-029 Shared package holds bus request struct (we, addr, be, wdata), FSM state enum, master index type.
REQ-030 Tag FIFO is one sub-module, mbus_tag_fifo (parameterised depth, width 1, push/pop/full/empty/count).
REQ-031 Block targets 150-300 lines RTL; no memory macros.

Verification
REQ-032 Both masters read simultaneously from reset, s_ack_i=1: m0 (0x100) granted cycle 0, m1 (0x200) cycle 1; responses 0xAAAA, 0xBBBB routed m0 then m1.
REQ-033 m0 write, s_ack_i=0 for 3 cycles, m1 req from cycle 1: s_addr_bo stays m0 address until ack, m1 granted next cycle.
REQ-034 RD_DEPTH=4, 4 m1 reads accepted, no responses: 5th read req ack=0, m0 write 0x300 accepted; one response frees slot, read accepted next cycle.
REQ-035 Count full, s_resp_i and new read same cycle: read not acked that cycle, rd_cnt_o 4->3, read accepted next cycle, count back to 4.
REQ-036 s_resp_i pulse with no outstanding reads: no mN_resp_o, rsp_err_o=1 next cycle, stays 1; arst_i clears it.
REQ-037 arst_i pulse with 2 reads outstanding: rd_cnt_o=0 immediately; subsequent 2 responses -> rsp_err_o=1, no master resp.
